// File: rtl/riscv_pkg.sv
// Shared RV32I control encodings: opcodes, FSM states and datapath select codes.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_ALU    = 2'b10;

    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    typedef struct packed {
        logic op;
        logic op_imm;
        logic load;
        logic store;
        logic branch;
        logic lui;
        logic auipc;
        logic jal;
        logic jalr;
        logic fence;
    } iclass_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier: one-hot instruction class plus legal flag.
module opcode_class_decode
    import riscv_pkg::*;
(
    input  logic [6:0] i_opcode,
    output iclass_t    o_class,
    output logic       o_legal
);

    always_comb begin
        o_class = '0;
        case (i_opcode)
            OPC_OP:     o_class.op     = 1'b1;
            OPC_OP_IMM: o_class.op_imm = 1'b1;
            OPC_LOAD:   o_class.load   = 1'b1;
            OPC_STORE:  o_class.store  = 1'b1;
            OPC_BRANCH: o_class.branch = 1'b1;
            OPC_LUI:    o_class.lui    = 1'b1;
            OPC_AUIPC:  o_class.auipc  = 1'b1;
            OPC_JAL:    o_class.jal    = 1'b1;
            OPC_JALR:   o_class.jalr   = 1'b1;
            OPC_FENCE:  o_class.fence  = 1'b1;
            default:    o_class        = '0;
        endcase
        o_legal = |o_class;
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main control FSM (FETCH/DECODE/EXEC/MEM/WB[/TRAP]).
// Define MULTICYCLE_TRAP_EN to trap unsupported opcodes instead of treating them as NOP.
module multicycle_control
    import riscv_pkg::*;
#(
    parameter int unsigned RESET_STATE_FETCH = 1
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       br_taken,
    output logic       imem_req,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       rf_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic [1:0] alu_op,
    output logic       f7_mask,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       illegal
);

    if (RESET_STATE_FETCH != 1) begin : g_param_check
        $error("multicycle_control: RESET_STATE_FETCH must be 1");
    end

    state_t  r_state;
    state_t  w_next;
    iclass_t w_class;
    logic    w_legal;
    logic    w_nop;

    opcode_class_decode u_decode (
        .i_opcode (opcode),
        .o_class  (w_class),
        .o_legal  (w_legal)
    );

`ifdef MULTICYCLE_TRAP_EN
    assign w_nop = w_class.fence;
`else
    assign w_nop = w_class.fence | ~w_legal;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_FETCH;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:  if (imem_ready) w_next = ST_DECODE;
            ST_DECODE: begin
                if (w_nop)         w_next = ST_FETCH;
                else if (!w_legal) w_next = ST_TRAP;
                else               w_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (w_class.load | w_class.store) w_next = ST_MEM;
                else if (w_class.branch)          w_next = ST_FETCH;
                else                              w_next = ST_WB;
            end
            ST_MEM: begin
                if (dmem_ready) w_next = w_class.load ? ST_WB : ST_FETCH;
            end
            ST_WB:   w_next = ST_FETCH;
`ifdef MULTICYCLE_TRAP_EN
            ST_TRAP: w_next = ST_TRAP;
`endif
            default: w_next = ST_FETCH;
        endcase
    end

    // Outputs are forced low while reset is asserted so an aborted instruction never commits.
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_PLUS4;
        alu_op    = ALU_OP_ADD;
        f7_mask   = 1'b0;
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        wb_sel    = WB_SEL_ALU;
        retire    = 1'b0;
        illegal   = 1'b0;
        if (reset_n) begin
            case (r_state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                ST_DECODE: begin
                    if (w_nop) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (w_class.op) begin
                        alu_op = ALU_OP_FUNCT;
                    end else if (w_class.op_imm) begin
                        alu_op    = ALU_OP_FUNCT;
                        alu_src_b = SRC_B_IMM;
                        f7_mask   = (funct3 != F3_SRX);
                    end else if (w_class.branch) begin
                        alu_op = ALU_OP_SUB;
                        pc_we  = 1'b1;
                        pc_sel = br_taken ? PC_SEL_BRANCH : PC_SEL_PLUS4;
                        retire = 1'b1;
                    end else begin
                        alu_src_b = SRC_B_IMM;
                        if (w_class.lui)                      alu_src_a = SRC_A_ZERO;
                        else if (w_class.auipc | w_class.jal) alu_src_a = SRC_A_PC;
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = w_class.store;
                    if (dmem_ready && w_class.store) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end
                end
                ST_WB: begin
                    rf_we  = 1'b1;
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    if (w_class.load) begin
                        wb_sel = WB_SEL_LOAD;
                    end else if (w_class.jal | w_class.jalr) begin
                        wb_sel = WB_SEL_PC4;
                        pc_sel = PC_SEL_ALU;
                    end
                end
`ifdef MULTICYCLE_TRAP_EN
                ST_TRAP: illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: expected per-cycle outputs queued with stimulus.
module tb_multicycle_control;

    localparam logic [6:0] T_OP     = 7'b0110011;
    localparam logic [6:0] T_OPIMM  = 7'b0010011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_FENCE  = 7'b0001111;
    localparam logic [6:0] T_BAD    = 7'b1111111;

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       dmem_req;
        logic       dmem_we;
        logic       rf_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic [1:0] alu_op;
        logic       f7_mask;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] wb_sel;
        logic       retire;
        logic       illegal;
    } outs_t;

    typedef struct packed {
        outs_t      o;
        logic       imr;
        logic       dmr;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       br;
    } step_t;

    logic       clk = 1'b0;
    logic       reset_n, imem_ready, dmem_ready, br_taken;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, f7_mask, retire, illegal;
    logic [1:0] pc_sel, alu_op, alu_src_a, alu_src_b, wb_sel;
    outs_t      w_obs;

    int    total = 0;
    int    bad   = 0;
    step_t sb[$];

    always #5 clk = ~clk;

    multicycle_control #(.RESET_STATE_FETCH(1)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .br_taken(br_taken),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_op(alu_op), .f7_mask(f7_mask),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .wb_sel(wb_sel),
        .retire(retire), .illegal(illegal)
    );

    assign w_obs = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, alu_op,
                    f7_mask, alu_src_a, alu_src_b, wb_sel, retire, illegal};

    task automatic push_step(input outs_t o, input logic imr, input logic dmr,
                             input logic [6:0] opc, input logic [2:0] f3, input logic br);
        step_t s;
        s.o = o; s.imr = imr; s.dmr = dmr; s.opc = opc; s.f3 = f3; s.br = br;
        sb.push_back(s);
    endtask

    // Expected cycle-by-cycle trace for one instruction; ready is driven high in
    // cycles where the DUT must ignore it.
    task automatic push_instr(input logic [6:0] opc, input logic [2:0] f3, input logic br,
                              input int unsigned wi, input int unsigned wd);
        outs_t e;
        bit    known;
        known = (opc inside {T_OP, T_OPIMM, T_LOAD, T_STORE, T_BRANCH, T_LUI,
                             T_AUIPC, T_JAL, T_JALR, T_FENCE});
        for (int unsigned i = 0; i < wi; i++) begin
            e = '0; e.imem_req = 1'b1;
            push_step(e, 1'b0, 1'b1, opc, f3, br);
        end
        e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1;
        push_step(e, 1'b1, 1'b0, opc, f3, br);
        e = '0;
`ifdef MULTICYCLE_TRAP_EN
        if (!known) begin
            push_step(e, 1'b1, 1'b1, opc, f3, br);
            e.illegal = 1'b1;
            for (int k = 0; k < 3; k++) push_step(e, 1'b1, 1'b1, opc, f3, br);
            return;
        end
`endif
        if (opc == T_FENCE || !known) begin
            e.pc_we = 1'b1; e.retire = 1'b1;
            push_step(e, 1'b1, 1'b1, opc, f3, br);
            return;
        end
        push_step(e, 1'b1, 1'b1, opc, f3, br);
        e = '0;
        case (opc)
            T_OP:     e.alu_op = 2'b10;
            T_OPIMM:  begin e.alu_op = 2'b10; e.src_b = 2'b01; e.f7_mask = (f3 != 3'b101); end
            T_LOAD, T_STORE, T_JALR: e.src_b = 2'b01;
            T_BRANCH: begin
                e.alu_op = 2'b01; e.pc_we = 1'b1; e.retire = 1'b1;
                e.pc_sel = br ? 2'b01 : 2'b00;
            end
            T_LUI:    begin e.src_a = 2'b10; e.src_b = 2'b01; end
            default:  begin e.src_a = 2'b01; e.src_b = 2'b01; end
        endcase
        push_step(e, 1'b1, 1'b1, opc, f3, br);
        if (opc == T_BRANCH) return;
        if (opc == T_LOAD || opc == T_STORE) begin
            e = '0; e.dmem_req = 1'b1; e.dmem_we = (opc == T_STORE);
            for (int unsigned i = 0; i < wd; i++) push_step(e, 1'b1, 1'b0, opc, f3, br);
            if (opc == T_STORE) begin
                e.pc_we = 1'b1; e.retire = 1'b1;
                push_step(e, 1'b1, 1'b1, opc, f3, br);
                return;
            end
            push_step(e, 1'b1, 1'b1, opc, f3, br);
        end
        e = '0; e.rf_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1;
        if (opc == T_LOAD) e.wb_sel = 2'b01;
        if (opc == T_JAL || opc == T_JALR) begin e.wb_sel = 2'b10; e.pc_sel = 2'b10; end
        push_step(e, 1'b1, 1'b1, opc, f3, br);
    endtask

    task automatic test_reset();
        outs_t e;
        reset_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; br_taken = 1'b0;
        opcode = T_STORE; funct3 = 3'b010;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (w_obs !== outs_t'('0)) begin
                bad++; $display("FAIL reset_hold got=%h want=0", w_obs);
            end
            @(posedge clk); #1;
        end
        reset_n = 1'b1; imem_ready = 1'b0;
        @(negedge clk);
        e = '0; e.imem_req = 1'b1;
        total++;
        if (w_obs !== e) begin bad++; $display("FAIL reset_release got=%h want=%h", w_obs, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        step_t s;
        int    n = 0;
        push_instr(T_OP,    3'b000, 1'b0, 0, 0);
        push_instr(T_OPIMM, 3'b000, 1'b0, 0, 0);
        push_instr(T_OPIMM, 3'b101, 1'b0, 1, 0);
        push_instr(T_OPIMM, 3'b111, 1'b0, 0, 0);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            opcode = s.opc; funct3 = s.f3; br_taken = s.br; imem_ready = s.imr; dmem_ready = s.dmr;
            @(negedge clk);
            total++;
            if (w_obs !== s.o) begin bad++; $display("FAIL alu step%0d got=%h want=%h", n, w_obs, s.o); end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        step_t s;
        int    n = 0;
        push_instr(T_BRANCH, 3'b000, 1'b1, 0, 0);
        push_instr(T_BRANCH, 3'b000, 1'b0, 0, 0);
        push_instr(T_BRANCH, 3'b001, 1'b1, 2, 0);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            opcode = s.opc; funct3 = s.f3; br_taken = s.br; imem_ready = s.imr; dmem_ready = s.dmr;
            @(negedge clk);
            total++;
            if (w_obs !== s.o) begin bad++; $display("FAIL branch step%0d got=%h want=%h", n, w_obs, s.o); end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_wait();
        step_t s;
        int    n = 0;
        int    ret_cyc = -1;
        push_instr(T_LOAD, 3'b010, 1'b0, 0, 3);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            opcode = s.opc; funct3 = s.f3; br_taken = s.br; imem_ready = s.imr; dmem_ready = s.dmr;
            @(negedge clk);
            total++;
            if (w_obs !== s.o) begin bad++; $display("FAIL load step%0d got=%h want=%h", n, w_obs, s.o); end
            if (retire === 1'b1 && ret_cyc < 0) ret_cyc = n;
            n++;
            @(posedge clk); #1;
        end
        total++;
        if (ret_cyc != 7) begin bad++; $display("FAIL load_retire_cycle got=%0d want=7", ret_cyc); end
    endtask

    task automatic test_jump_upper();
        step_t s;
        int    n = 0;
        push_instr(T_LUI,   3'b000, 1'b0, 0, 0);
        push_instr(T_AUIPC, 3'b000, 1'b0, 0, 0);
        push_instr(T_JAL,   3'b000, 1'b0, 0, 0);
        push_instr(T_JALR,  3'b000, 1'b0, 1, 0);
        push_instr(T_FENCE, 3'b000, 1'b0, 0, 0);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            opcode = s.opc; funct3 = s.f3; br_taken = s.br; imem_ready = s.imr; dmem_ready = s.dmr;
            @(negedge clk);
            total++;
            if (w_obs !== s.o) begin bad++; $display("FAIL jump step%0d got=%h want=%h", n, w_obs, s.o); end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        step_t s;
        int    n = 0;
        push_instr(T_STORE,  3'b010, 1'b0, 0, 0);
        push_instr(T_LOAD,   3'b010, 1'b0, 1, 0);
        push_instr(T_STORE,  3'b010, 1'b0, 0, 2);
        push_instr(T_OP,     3'b000, 1'b0, 0, 0);
        push_instr(T_FENCE,  3'b000, 1'b0, 2, 0);
        push_instr(T_BRANCH, 3'b000, 1'b1, 0, 0);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            opcode = s.opc; funct3 = s.f3; br_taken = s.br; imem_ready = s.imr; dmem_ready = s.dmr;
            @(negedge clk);
            total++;
            if (w_obs !== s.o) begin bad++; $display("FAIL b2b step%0d got=%h want=%h", n, w_obs, s.o); end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_reset();
        step_t s;
        outs_t e;
        push_instr(T_STORE, 3'b010, 1'b0, 0, 5);
        for (int n = 0; n < 4; n++) begin
            s = sb.pop_front();
            opcode = s.opc; funct3 = s.f3; br_taken = s.br; imem_ready = s.imr; dmem_ready = s.dmr;
            @(negedge clk);
            total++;
            if (w_obs !== s.o) begin bad++; $display("FAIL sw_pre step%0d got=%h want=%h", n, w_obs, s.o); end
            @(posedge clk); #1;
        end
        sb.delete();
        reset_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (w_obs !== outs_t'('0)) begin bad++; $display("FAIL sw_reset got=%h want=0", w_obs); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        e = '0; e.imem_req = 1'b1;
        total++;
        if (w_obs !== e) begin bad++; $display("FAIL sw_after_reset got=%h want=%h", w_obs, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        step_t s;
        outs_t e;
        int    n = 0;
        push_instr(T_BAD, 3'b000, 1'b0, 0, 0);
        while (sb.size() != 0) begin
            s = sb.pop_front();
            opcode = s.opc; funct3 = s.f3; br_taken = s.br; imem_ready = s.imr; dmem_ready = s.dmr;
            @(negedge clk);
            total++;
            if (w_obs !== s.o) begin bad++; $display("FAIL illegal step%0d got=%h want=%h", n, w_obs, s.o); end
            n++;
            @(posedge clk); #1;
        end
        reset_n = 1'b0; imem_ready = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        e = '0; e.imem_req = 1'b1;
        total++;
        if (w_obs !== e) begin bad++; $display("FAIL illegal_exit got=%h want=%h", w_obs, e); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_load_wait();
        test_jump_upper();
        test_back_to_back();
        test_store_reset();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
